// File: rtl/multicycle_main_control_if.sv
// Control/status bundle between the RV32I multi-cycle main control FSM and its datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave modport.
interface multicycle_main_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regwrite, alusrca, alusrcb, aluop, pcsource,
               illegal_op, bus_error, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regwrite, alusrca, alusrcb, aluop, pcsource,
               illegal_op, bus_error, state
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Multi-cycle RV32I main control FSM: sequences fetch, decode, execute, memory and
// writeback, driving every datapath enable and mux select from the current state.
module multicycle_main_control #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_main_control_if.master bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC_R = 4'd7,
        EXEC_I = 4'd8,
        ALUWB  = 4'd9,
        BRANCH = 4'd10,
        JAL    = 4'd11
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam bit         TIMEOUT_EN  = (MEM_TIMEOUT > 0);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;
    logic       mem_state;
    logic       mem_stall;
    logic       timeout_hit;

    // zero only qualifies pcwritecond inside the datapath; the FSM never branches on it.
    logic unused_zero;
    assign unused_zero = bus.zero;

    function automatic state_t decode_target(input logic [6:0] op);
        case (op)
            OP_RTYPE:          return EXEC_R;
            OP_ITYPE:          return EXEC_I;
            OP_LOAD, OP_STORE: return MEMADR;
            OP_BRANCH:         return BRANCH;
            OP_JAL:            return JAL;
            default:           return FETCH;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        return op inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign mem_state   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign mem_stall   = mem_state && !bus.mem_ready;
    assign timeout_hit = TIMEOUT_EN && mem_stall && (wait_cnt_q == TIMEOUT_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A stall keeps the state unchanged, so only stalled cycles that did not time out
    // carry the count forward; every other cycle is a state change (or re-entry) and clears it.
    always_comb begin
        wait_cnt_d = '0;
        if (TIMEOUT_EN && mem_stall && !timeout_hit) begin
            wait_cnt_d = sat_inc(wait_cnt_q);
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.memtoreg    = 2'b00;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 2'b00;
        bus.alusrcb     = 2'b00;
        bus.aluop       = 2'b00;
        bus.pcsource    = 2'b00;
        bus.illegal_op  = 1'b0;
        bus.bus_error   = timeout_hit;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            // PC+4 is computed every FETCH cycle but only committed with the instruction word.
            FETCH: begin
                bus.memread  = 1'b1;
                bus.alusrca  = 2'b00;
                bus.alusrcb  = 2'b01;
                bus.aluop    = 2'b00;
                bus.pcsource = 2'b00;
                bus.irwrite  = bus.mem_ready;
                bus.pcwrite  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d = FETCH;
                end
            end

            // oldPC + imm lands in aluout here so BRANCH and JAL can use it directly.
            DECODE: begin
                bus.alusrca    = 2'b10;
                bus.alusrcb    = 2'b10;
                bus.aluop      = 2'b00;
                bus.illegal_op = !op_supported(bus.opcode);
                state_d        = decode_target(bus.opcode);
            end

            MEMADR: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b00;
                state_d     = (bus.opcode == OP_LOAD) ? MEMRD : MEMWR;
            end

            MEMRD: begin
                bus.iord    = 1'b1;
                bus.memread = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout_hit) begin
                    state_d = FETCH;
                end
            end

            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b01;
                state_d      = FETCH;
            end

            MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (bus.mem_ready || timeout_hit) begin
                    state_d = FETCH;
                end
            end

            EXEC_R: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b00;
                bus.aluop   = 2'b10;
                state_d     = ALUWB;
            end

            EXEC_I: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b10;
                state_d     = ALUWB;
            end

            ALUWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b00;
                state_d      = FETCH;
            end

            BRANCH: begin
                bus.alusrca     = 2'b01;
                bus.alusrcb     = 2'b00;
                bus.aluop       = 2'b01;
                bus.pcwritecond = 1'b1;
                bus.pcsource    = 2'b01;
                state_d         = FETCH;
            end

            // PC already holds oldPC+4 from FETCH, which is exactly the link value.
            JAL: begin
                bus.pcwrite  = 1'b1;
                bus.pcsource = 2'b01;
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b10;
                state_d      = FETCH;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: two instances (no timeout, timeout=4) on shared inputs,
// checked every cycle against an instruction-level plan model plus literal spot checks.
module tb_multicycle_main_control;

    localparam int TO4 = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [31:0] instr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    multicycle_main_control_if if0 ();
    multicycle_main_control_if if4 ();

    assign if0.opcode    = opcode;
    assign if0.zero      = zero;
    assign if0.mem_ready = mem_ready;
    assign if4.opcode    = opcode;
    assign if4.zero      = zero;
    assign if4.mem_ready = mem_ready;

    multicycle_main_control #(.MEM_TIMEOUT(0))   dut0 (.clk(clk), .reset(reset), .bus(if0));
    multicycle_main_control #(.MEM_TIMEOUT(TO4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    always #5 clk = ~clk;

    logic [22:0] act0;
    logic [22:0] act4;
    assign act0 = {if0.pcwrite, if0.pcwritecond, if0.iord, if0.memread, if0.memwrite, if0.irwrite,
                   if0.memtoreg, if0.regwrite, if0.alusrca, if0.alusrcb, if0.aluop, if0.pcsource,
                   if0.illegal_op, if0.bus_error, if0.state};
    assign act4 = {if4.pcwrite, if4.pcwritecond, if4.iord, if4.memread, if4.memwrite, if4.irwrite,
                   if4.memtoreg, if4.regwrite, if4.alusrca, if4.alusrcb, if4.aluop, if4.pcsource,
                   if4.illegal_op, if4.bus_error, if4.state};

    // Control word: {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regwrite,
    //                alusrca,alusrcb,aluop,pcsource}
    function automatic logic [16:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic [1:0] mtr, input logic rw,
                                       input logic [1:0] asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] psrc);
        return {pcw, pcwc, iord, mr, mw, irw, mtr, rw, asa, asb, aop, psrc};
    endfunction

    logic [16:0] tbl [0:15];
    int mst   [2];
    int mwait [2];
    int plan  [2][4];
    int plen  [2];
    int ppos  [2];

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        tbl[1]  = mk(0,0,0,1,0,0,2'b00,0,2'b00,2'b01,2'b00,2'b00);
        tbl[2]  = mk(0,0,0,0,0,0,2'b00,0,2'b10,2'b10,2'b00,2'b00);
        tbl[3]  = mk(0,0,0,0,0,0,2'b00,0,2'b01,2'b10,2'b00,2'b00);
        tbl[4]  = mk(0,0,1,1,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00);
        tbl[5]  = mk(0,0,0,0,0,0,2'b01,1,2'b00,2'b00,2'b00,2'b00);
        tbl[6]  = mk(0,0,1,0,1,0,2'b00,0,2'b00,2'b00,2'b00,2'b00);
        tbl[7]  = mk(0,0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b10,2'b00);
        tbl[8]  = mk(0,0,0,0,0,0,2'b00,0,2'b01,2'b10,2'b10,2'b00);
        tbl[9]  = mk(0,0,0,0,0,0,2'b00,1,2'b00,2'b00,2'b00,2'b00);
        tbl[10] = mk(0,1,0,0,0,0,2'b00,0,2'b01,2'b00,2'b01,2'b01);
        tbl[11] = mk(1,0,0,0,0,0,2'b10,1,2'b00,2'b00,2'b00,2'b01);
        for (int k = 0; k < 2; k++) begin
            mst[k] = 0; mwait[k] = 0; plen[k] = 0; ppos[k] = 0;
        end
    end

    task automatic pop_plan(input int k, output int nst);
        if (ppos[k] < plen[k]) begin
            nst = plan[k][ppos[k]];
            ppos[k]++;
        end else begin
            nst = 1;
        end
    endtask

    // One instruction = FETCH, DECODE, then a per-opcode list of phases; FETCH/MEMRD/MEMWR wait on mem_ready.
    task automatic model_step(input int k, output logic [22:0] e);
        int          st;
        int          nst;
        int          to;
        logic [16:0] c;
        logic        ill;
        logic        be;
        to  = (k == 0) ? 0 : TO4;
        st  = mst[k];
        ill = 1'b0;
        be  = 1'b0;
        if (reset) begin
            mst[k] = 0; mwait[k] = 0; plen[k] = 0; ppos[k] = 0;
            e = '0;
            return;
        end
        c   = tbl[st];
        nst = st;
        if (st == 0) begin
            nst = 1;
        end else if (st == 1 || st == 4 || st == 6) begin
            if (st == 1) c = c | mk(mem_ready,0,0,0,0,mem_ready,2'b00,0,2'b00,2'b00,2'b00,2'b00);
            if (mem_ready) begin
                if (st == 1) nst = 2;
                else pop_plan(k, nst);
            end else if (to > 0 && mwait[k] == to) begin
                be  = 1'b1;
                nst = 1;
            end else begin
                mwait[k]++;
            end
        end else if (st == 2) begin
            plen[k] = 0;
            ppos[k] = 0;
            case (opcode)
                7'b0110011: begin plan[k][0] = 7;  plan[k][1] = 9; plen[k] = 2; end
                7'b0010011: begin plan[k][0] = 8;  plan[k][1] = 9; plen[k] = 2; end
                7'b0000011: begin plan[k][0] = 3;  plan[k][1] = 4; plan[k][2] = 5; plen[k] = 3; end
                7'b0100011: begin plan[k][0] = 3;  plan[k][1] = 6; plen[k] = 2; end
                7'b1100011: begin plan[k][0] = 10; plen[k] = 1; end
                7'b1101111: begin plan[k][0] = 11; plen[k] = 1; end
                default:    ill = 1'b1;
            endcase
            pop_plan(k, nst);
        end else begin
            pop_plan(k, nst);
        end
        if (nst != st || be) mwait[k] = 0;
        mst[k] = nst;
        e = {c, ill, be, 4'(st)};
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            model_step(k, e);
            n_checks++;
            if (((k == 0) ? act0 : act4) !== e) begin
                n_fail++;
                $display("FAIL model_cmp dut%0d cycle %0d: got 0x%06h, expected 0x%06h",
                         (k == 0) ? 0 : TO4, cyc, (k == 0) ? act0 : act4, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        instr     = 32'h007302B3;
        tick(); tick();
        #1;
        chk("reset_outputs_dut0", {9'd0, act0}, 32'd0);
        chk("reset_outputs_dut4", {9'd0, act4}, 32'd0);
        reset  = 1'b0;
        opcode = instr[6:0];
        #1;
        chk("idle_after_release", 32'(if0.state), 32'd0);

        // R-type: 0,1,2,7,9,1
        tick(); #1;
        chk("r_fetch_state", 32'(if0.state), 32'd1);
        chk("r_fetch_irwrite", 32'(if0.irwrite), 32'd1);
        tick(); #1;
        chk("r_decode_state", 32'(if0.state), 32'd2);
        tick(); #1;
        chk("r_exec_state", 32'(if0.state), 32'd7);
        chk("r_exec_aluop", 32'(if0.aluop), 32'd2);
        chk("r_exec_regwrite", 32'(if0.regwrite), 32'd0);
        tick(); #1;
        chk("r_aluwb_state", 32'(if0.state), 32'd9);
        chk("r_aluwb_regwrite", 32'(if0.regwrite), 32'd1);
        tick(); #1;
        chk("r_back_fetch", 32'(if0.state), 32'd1);

        // Load, MEMRD stretched by three not-ready cycles
        opcode = 7'b0000011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("ld_memrd_state", 32'(if0.state), 32'd4);
        chk("ld_memrd_iord_memread", {30'd0, if0.iord, if0.memread}, 32'd3);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("ld_memrd_hold", {26'd0, if0.iord, if0.memread, if0.state}, 32'h34);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        chk("ld_memrd_last", 32'(if4.state), 32'd4);
        tick(); #1;
        chk("ld_memwb_state", 32'(if0.state), 32'd5);
        chk("ld_memwb_ctrl", {29'd0, if0.memtoreg, if0.regwrite}, 32'd3);
        tick(); #1;
        chk("ld_back_fetch", 32'(if0.state), 32'd1);

        // Branch, zero=1 then zero=0: same controls, 3 cycles each
        for (int z = 1; z >= 0; z--) begin
            opcode = 7'b1100011;
            zero   = z[0];
            tick(); tick(); #1;
            chk("br_state", 32'(if0.state), 32'd10);
            chk("br_ctrl", {27'd0, if0.aluop, if0.pcwritecond, if0.pcsource}, 32'b01_1_01);
            tick(); #1;
            chk("br_back_fetch", 32'(if0.state), 32'd1);
        end

        // Unsupported opcode
        opcode = 7'b1111111;
        tick(); #1;
        chk("ill_decode_pulse", {30'd0, if0.illegal_op, if4.illegal_op}, 32'd3);
        tick(); #1;
        chk("ill_next_fetch", 32'(if0.state), 32'd1);
        chk("ill_pulse_gone", {29'd0, if0.illegal_op, if0.regwrite, if0.memwrite}, 32'd0);

        // I-type then JAL
        opcode = 7'b0010011;
        repeat (4) tick();
        #1;
        chk("itype_back_fetch", 32'(if0.state), 32'd1);
        opcode = 7'b1101111;
        tick(); tick(); #1;
        chk("jal_state", 32'(if0.state), 32'd11);
        chk("jal_ctrl", {27'd0, if0.pcwrite, if0.regwrite, if0.memtoreg, 1'b0}, 32'b1_1_10_0);
        tick();

        // Store with two wait cycles in MEMWR
        opcode = 7'b0100011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("st_memwr_state", 32'(if0.state), 32'd6);
        tick(); tick();
        mem_ready = 1'b1;
        tick(); #1;
        chk("st_back_fetch", 32'(if0.state), 32'd1);

        // Fetch timeout on the timeout=4 instance: bus_error on FETCH cycles 5 and 10
        mem_ready = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            chk("to_bus_error", 32'(if4.bus_error), (c == 5 || c == 10) ? 32'd1 : 32'd0);
            chk("to_state_fetch", {27'd0, if0.bus_error, if4.state}, 32'd1);
            tick();
        end
        mem_ready = 1'b1;

        // Reset asserted mid-MEMWR: outputs drop without waiting for a clock edge
        opcode = 7'b0100011;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("rst_pre_memwrite", {30'd0, if0.memwrite, if4.memwrite}, 32'd3);
        reset = 1'b1;
        #1;
        chk("rst_async_memwrite", {30'd0, if0.memwrite, if4.memwrite}, 32'd0);
        chk("rst_async_state", {24'd0, if0.state, if4.state}, 32'd0);
        tick(); tick();
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_release_idle", 32'(if0.state), 32'd0);
        tick(); #1;
        chk("rst_first_fetch", {24'd0, if0.state, if4.state}, 32'h11);
        tick(); tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the RV32I datapath.
- Decodes the 7-bit opcode of the latched instruction and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, including the 2-bit aluop that feeds the ALU control unit (ALUCU).
- Sits between the instruction register and the datapath; a memory handshake (mem_ready) stretches the memory states.

Parameters:
- MEM_TIMEOUT, 0, maximum wait cycles in a memory state before bus_error; 0 disables the timeout (wait indefinitely).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- opcode  input  7  instruction[6:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- pcwrite  output  1  unconditional PC load
- pcwritecond  output  1  PC load when zero=1 (beq)
- iord  output  1  memory address select: 0=PC, 1=aluout
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- irwrite  output  1  load IR and oldPC
- memtoreg  output  2  writeback source: 00=aluout, 01=MDR, 10=PC
- regwrite  output  1  register file write
- alusrca  output  2  ALU A: 00=PC, 01=rs1, 10=oldPC
- alusrcb  output  2  ALU B: 00=rs2, 01=const 4, 10=imm
- aluop  output  2  00=add, 01=subtract, 10=funct decode
- pcsource  output  2  00=ALU result, 01=aluout register
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- bus_error  output  1  one-cycle pulse on memory timeout
- state  output  4  current state encoding (debug)

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, EXEC_I=8, ALUWB=9, BRANCH=10, JAL=11.
- Reset (asynchronous): state=IDLE, wait counter=0. In IDLE all outputs are 0. IDLE always goes to FETCH on the next edge.
- Outputs are decoded from the current state (Moore) except where a line below says they are gated by mem_ready. Any output not listed for a state is 0.
- FETCH: memread=1, alusrca=00, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite = mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alusrca=10, alusrcb=10, aluop=00 (precomputes the branch/jump target into aluout). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> FETCH, with illegal_op=1 during DECODE.
- MEMADR: alusrca=01, alusrcb=10, aluop=00. Next state is MEMRD if opcode=0000011, otherwise MEMWR.
- MEMRD: iord=1, memread=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: regwrite=1, memtoreg=01. Next state FETCH.
- MEMWR: iord=1, memwrite=1. Hold until mem_ready=1, then FETCH.
- EXEC_R: alusrca=01, alusrcb=00, aluop=10. Next state ALUWB.
- EXEC_I: alusrca=01, alusrcb=10, aluop=10. Next state ALUWB.
- ALUWB: regwrite=1, memtoreg=00. Next state FETCH.
- BRANCH: alusrca=01, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Next state FETCH.
- JAL: pcwrite=1, pcsource=01, regwrite=1, memtoreg=10 (PC already holds oldPC+4). Next state FETCH.
- Cycle counts with zero wait: R-type 4, I-type 4, load 5, store 4, branch 3, jal 3.
- Wait counter (only meaningful when MEM_TIMEOUT>0):
  - 8-bit, counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on every state change.
  - When the count equals MEM_TIMEOUT and mem_ready is still 0: bus_error=1 for that cycle, next state FETCH, counter clears.
  - If mem_ready=1 in the same cycle as the timeout, mem_ready wins and bus_error stays 0.
- A reset asserted mid-instruction returns to IDLE immediately; outputs go to 0 asynchronously.

Test Plan:
- Reset, then opcode=0110011 (instruction 0x007302B3) with mem_ready=1 -> state 0,1,2,7,9,1; aluop=10 in EXEC_R; regwrite=1 only in ALUWB.
- Load 0000011 with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, memread/iord stable, MEMWB asserts memtoreg=01 and regwrite=1.
- Branch 1100011, once with zero=1 and once with zero=0 -> BRANCH shows aluop=01, pcwritecond=1 and pcsource=01 in both runs; 3 cycles total each.
- Opcode 1111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, no regwrite/memwrite.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error pulses on the 5th FETCH cycle, FETCH re-entered, counter=0.
- Assert reset during MEMWR -> memwrite drops to 0 before the next clock edge; state=0; FETCH on the first edge after release.
